// File: rtl/instr_loader.sv
// instr_loader: streams a length-prefixed, big-endian word image into instruction memory while
// holding the CPU. Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byteValid_i,
    output logic        byteReady_o,
    output logic        memWrite_o,
    output logic [31:0] memAddr_o,
    output logic [31:0] memData_o,
    output logic        cpuHold_o,
    output logic        done_o,
    output logic        error_o
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StHdrHi, StHdrLo, StData, StChk, StDone, StError} state_e;
`else
    typedef enum logic [2:0] {StIdle, StHdrHi, StHdrLo, StData, StDone, StError} state_e;
`endif

    localparam logic [16:0] DepthW = 17'(DEPTH);

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q;
    logic [16:0] word_idx_q;
    logic [15:0] count_q;
    logic [23:0] word_buf_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_q;
    logic        accept;
    logic        last_write;
    logic        enter_hdr;
    logic [16:0] hdr_count;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]  chk_q;
`endif

    assign accept    = byteValid_i && byteReady_o;
    assign hdr_count = {1'b0, count_q[15:8], byte_i};
    // word_idx_q equals the word count only in the cycle the final word is being written
    assign last_write = (word_idx_q == {1'b0, count_q});
    assign enter_hdr  = (state_d == StHdrHi) && (state_q != StHdrHi);

    assign memWrite_o = mem_write_q;
    assign memAddr_o  = mem_addr_q;
    assign memData_o  = mem_data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byteReady_o = 1'b0;
        cpuHold_o   = (state_q != StDone);
        done_o      = (state_q == StDone);
        error_o     = (state_q == StError);
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StHdrHi;
            end
            StHdrHi: begin
                byteReady_o = 1'b1;
                if (accept) state_d = StHdrLo;
            end
            StHdrLo: begin
                byteReady_o = 1'b1;
                if (accept) begin
                    if (hdr_count == 17'd0)         state_d = StDone;
                    else if (hdr_count > DepthW)    state_d = StError;
                    else                            state_d = StData;
                end
            end
            StData: begin
                if (last_write) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = StChk;
`else
                    state_d = StDone;
`endif
                end else begin
                    byteReady_o = 1'b1;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            StChk: begin
                byteReady_o = 1'b1;
                if (accept) state_d = (byte_i == chk_q) ? StDone : StError;
            end
`endif
            StDone, StError: begin
                if (start_i) state_d = StHdrHi;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            byte_cnt_q  <= 2'd0;
            word_idx_q  <= 17'd0;
            count_q     <= 16'd0;
            word_buf_q  <= 24'd0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_data_q  <= 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            chk_q       <= 8'd0;
`endif
        end else begin
            mem_write_q <= 1'b0;
            if (enter_hdr) begin
                byte_cnt_q <= 2'd0;
                word_idx_q <= 17'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                chk_q      <= 8'd0;
`endif
            end else if (accept) begin
                if (state_q == StHdrHi) count_q[15:8] <= byte_i;
                if (state_q == StHdrLo) count_q[7:0]  <= byte_i;
                if (state_q == StData) begin
                    byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    chk_q      <= chk_q ^ byte_i;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        mem_write_q <= 1'b1;
                        mem_data_q  <= {word_buf_q, byte_i};
                        mem_addr_q  <= BASE_ADDR + {13'd0, word_idx_q, 2'b00};
                        word_idx_q  <= word_idx_q + 17'd1;
                    end else begin
                        word_buf_q <= {word_buf_q[15:0], byte_i};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: a stream-level model predicts every output each cycle.
module tb_instr_loader;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n_i, start_i, byteValid_i;
    logic [7:0]  byte_i;
    logic        byteReady_o, memWrite_o, cpuHold_o, done_o, error_o;
    logic [31:0] memAddr_o, memData_o;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [7:0] stream[$];

    // model state
    bit          m_in_load, m_pend;
    int          m_pos, m_res, m_total;
    int unsigned m_n;
    logic [7:0]  m_xor;
    logic [31:0] wq_addr[$], wq_data[$];
    logic [31:0] m_last_addr, m_last_data;
    int          n_writes = 0;
    logic [31:0] seen_addr, seen_data;

    instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n_i),
        .start_i    (start_i),
        .byte_i     (byte_i),
        .byteValid_i(byteValid_i),
        .byteReady_o(byteReady_o),
        .memWrite_o (memWrite_o),
        .memAddr_o  (memAddr_o),
        .memData_o  (memData_o),
        .cpuHold_o  (cpuHold_o),
        .done_o     (done_o),
        .error_o    (error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_in_load   = 1'b0;
        m_pend      = 1'b0;
        m_pos       = 0;
        m_res       = 0;
        m_total     = 0;
        m_n         = 0;
        m_xor       = 8'h00;
        m_last_addr = BASE;
        m_last_data = 32'h0;
        wq_addr.delete();
        wq_data.delete();
    endfunction

    // A load begins: derive expected writes and byte budget straight from the stream.
    function automatic void m_start();
        m_in_load = 1'b1;
        m_pos     = 0;
        m_res     = 0;
        m_xor     = 8'h00;
        m_n       = {stream[0], stream[1]};
        m_total   = 2;
        wq_addr.delete();
        wq_data.delete();
        if (m_n >= 1 && m_n <= DEPTH) begin
            for (int i = 0; i < int'(m_n); i++) begin
                wq_addr.push_back(BASE + 32'(4 * i));
                wq_data.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
            end
            m_total = 2 + 4 * int'(m_n) + (CHK_EN ? 1 : 0);
        end
    endfunction

    initial begin
        bit exp_wr, last, rdy, acc;
        m_reset();
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_wr = m_pend;
            last   = 1'b0;
            check("memWrite", 32'(memWrite_o), 32'(exp_wr));
            if (exp_wr) begin
                check("memAddr", memAddr_o, wq_addr[0]);
                check("memData", memData_o, wq_data[0]);
                m_last_addr = wq_addr.pop_front();
                m_last_data = wq_data.pop_front();
                last        = (wq_addr.size() == 0);
                seen_addr   = memAddr_o;
                seen_data   = memData_o;
                n_writes++;
            end else begin
                check("memAddr hold", memAddr_o, m_last_addr);
                check("memData hold", memData_o, m_last_data);
            end
            rdy = m_in_load && (m_pos < m_total) && !(exp_wr && last);
            check("byteReady", 32'(byteReady_o), 32'(rdy));
            check("done", 32'(done_o), 32'(m_res == 1));
            check("error", 32'(error_o), 32'(m_res == 2));
            check("cpuHold", 32'(cpuHold_o), 32'(m_res != 1));

            if (!rst_n_i) begin
                m_reset();
            end else begin
                m_pend = 1'b0;
                if (exp_wr && last && !CHK_EN) begin
                    m_res     = 1;
                    m_in_load = 1'b0;
                end
                acc = byteValid_i && rdy;
                if (acc) begin
                    if (m_pos == 1) begin
                        if (m_n == 0) begin
                            m_res = 1; m_in_load = 1'b0;
                        end else if (m_n > DEPTH) begin
                            m_res = 2; m_in_load = 1'b0;
                        end
                    end else if (m_pos >= 2 && m_pos < 2 + 4 * int'(m_n)) begin
                        m_xor = m_xor ^ byte_i;
                        if ((m_pos - 2) % 4 == 3) m_pend = 1'b1;
                    end else if (m_pos >= 2) begin
                        m_res     = (byte_i == m_xor) ? 1 : 2;
                        m_in_load = 1'b0;
                    end
                    m_pos++;
                end
                if (start_i && !m_in_load) m_start();
            end
        end
    end

    function automatic void add_chk(input bit bad);
        logic [7:0] x;
        int unsigned n;
        x = 8'h00;
        n = {stream[0], stream[1]};
        if (CHK_EN && n >= 1 && n <= DEPTH) begin
            for (int i = 2; i < stream.size(); i++) x = x ^ stream[i];
            stream.push_back(bad ? (x ^ 8'h01) : x);
        end
    endfunction

    function automatic void build(input int unsigned n, input bit bad);
        stream.delete();
        stream.push_back(n[15:8]);
        stream.push_back(n[7:0]);
        if (n >= 1 && n <= DEPTH)
            for (int i = 0; i < 4 * int'(n); i++) stream.push_back(8'($urandom));
        add_chk(bad);
    endfunction

    task automatic run_load(input bit b2b, input int stop_after);
        int idx    = 0;
        int budget = 20000;
        int w      = 0;
        bit acc;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        while (idx < stream.size() && idx != stop_after && budget > 0) begin
            byte_i      = stream[idx];
            byteValid_i = b2b || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = byteValid_i && byteReady_o;
            @(posedge clk); #1;
            if (acc) idx++;
            budget--;
        end
        byteValid_i = 1'b0;
        if (budget == 0) begin
            assert_cnt++;
            fail_cnt++;
            $display("FAIL stream budget: accepted %0d of %0d bytes", idx, stream.size());
        end
        if (stop_after < 0) begin
            while (!(done_o || error_o) && w < 10) begin
                @(posedge clk); #1;
                w++;
            end
            check("load completes", 32'(done_o || error_o), 32'd1);
        end
    endtask

    initial begin
        int base_w;
        rst_n_i = 1'b0; start_i = 1'b0; byteValid_i = 1'b0; byte_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset memAddr", memAddr_o, BASE);
        check("reset memData", memData_o, 32'h0);
        check("reset cpuHold", 32'(cpuHold_o), 32'd1);
        check("reset ready", 32'(byteReady_o), 32'd0);
        rst_n_i = 1'b1;

        // single word image
        stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        add_chk(1'b0);
        run_load(1'b1, -1);
        check("one word count", 32'(n_writes), 32'd1);
        check("one word addr", seen_addr, 32'h0);
        check("one word data", seen_data, 32'hDEADBEEF);
        check("one word done", 32'(done_o), 32'd1);
        check("one word release", 32'(cpuHold_o), 32'd0);

        // three words back-to-back
        build(3, 1'b0);
        base_w = n_writes;
        run_load(1'b1, -1);
        check("three word count", 32'(n_writes - base_w), 32'd3);
        check("three word last addr", seen_addr, 32'h8);

        // oversize header
        stream = '{8'h01, 8'h01};
        base_w = n_writes;
        run_load(1'b0, -1);
        check("oversize error", 32'(error_o), 32'd1);
        check("oversize hold", 32'(cpuHold_o), 32'd1);
        check("oversize no write", 32'(n_writes - base_w), 32'd0);

        // empty image
        stream = '{8'h00, 8'h00};
        run_load(1'b1, -1);
        check("empty done", 32'(done_o), 32'd1);

`ifdef INSTR_LOADER_CHECKSUM_EN
        stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        run_load(1'b1, -1);
        check("bad checksum error", 32'(error_o), 32'd1);
        check("bad checksum word", seen_data, 32'h11223344);
        stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        run_load(1'b1, -1);
        check("good checksum done", 32'(done_o), 32'd1);
`endif

        // reset after two payload bytes
        build(2, 1'b0);
        base_w = n_writes;
        run_load(1'b1, 4);
        rst_n_i = 1'b0;
        @(posedge clk); #1;
        rst_n_i = 1'b1;
        check("abort memWrite", 32'(memWrite_o), 32'd0);
        check("abort memData", memData_o, 32'h0);
        check("abort memAddr", memAddr_o, BASE);
        repeat (3) @(posedge clk);
        #1;
        check("abort no write", 32'(n_writes - base_w), 32'd0);

        for (int t = 0; t < 24; t++) begin
            int unsigned sel, n;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       n = 0;
                1:       n = DEPTH;
                2:       n = DEPTH + 1;
                3:       n = $urandom_range(DEPTH + 2, 65535);
                default: n = $urandom_range(1, 6);
            endcase
            build(n, 1'($urandom_range(0, 1)));
            run_load(1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
